// File: rtl/cdb_broadcast_arbiter_if.sv
// Bundles the functional-unit request side and the CDB broadcast side of the
// arbiter. Directions and the i_/o_ prefixes are from the arbiter's viewpoint.
interface cdb_broadcast_arbiter_if #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_FU-1:0]            i_fu_done;
    logic [NUM_FU*DATA_WIDTH-1:0] i_fu_result;
    logic [NUM_FU*TAG_WIDTH-1:0]  i_fu_tag;
    logic [NUM_FU-1:0]            o_fu_queued;

    logic                         o_cdb_valid;
    logic [DATA_WIDTH-1:0]        o_cdb_data;
    logic [TAG_WIDTH-1:0]         o_cdb_tag;
    logic                         i_cdb_ready;

    logic [CNT_W-1:0]             o_fifo_count;
    logic                         o_fifo_full;

    modport slave (
        input  i_fu_done, i_fu_result, i_fu_tag, i_cdb_ready,
        output o_fu_queued, o_cdb_valid, o_cdb_data, o_cdb_tag,
        output o_fifo_count, o_fifo_full
    );

    modport master (
        output i_fu_done, i_fu_result, i_fu_tag, i_cdb_ready,
        input  o_fu_queued, o_cdb_valid, o_cdb_data, o_cdb_tag,
        input  o_fifo_count, o_fifo_full
    );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// Round-robin arbiter that funnels functional-unit results into a small
// broadcast FIFO whose head drives the common data bus. A granted FU sees
// o_fu_queued in the same cycle it asserts done, so it can release its result
// immediately; the CDB consumer drains the FIFO with a valid/ready handshake.
module cdb_broadcast_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cdb_broadcast_arbiter_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_FU);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;

    logic [IDX_W-1:0]   r_rrPtr;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    logic               w_pop;
    logic               w_canPush;
    logic               w_grantValid;
    logic [IDX_W-1:0]   w_grantIdx;
    logic [IDX_W-1:0]   w_scanIdx;
    int                 w_scanSum;
    logic [NUM_FU-1:0]  w_grantMask;
    logic [ENTRY_W-1:0] w_pushEntry;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a
    // push when the head is being consumed. Grants are suppressed in reset.
    assign w_pop     = (r_count != '0) & bus.i_cdb_ready;
    assign w_canPush = ~rst & ((r_count < CNT_W'(DEPTH)) | w_pop);

    // Round-robin search starting at r_rrPtr; first requester found wins.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_scanIdx    = '0;
        w_scanSum    = 0;
        w_grantMask  = '0;
        if (w_canPush) begin
            for (int k = 0; k < NUM_FU; k++) begin
                w_scanSum = int'(r_rrPtr) + k;
                if (w_scanSum >= NUM_FU) begin
                    w_scanSum = w_scanSum - NUM_FU;
                end
                w_scanIdx = IDX_W'(w_scanSum);
                if (!w_grantValid && bus.i_fu_done[w_scanIdx]) begin
                    w_grantValid = 1'b1;
                    w_grantIdx   = w_scanIdx;
                end
            end
        end
        if (w_grantValid) begin
            w_grantMask[w_grantIdx] = 1'b1;
        end
    end

    assign w_pushEntry = {bus.i_fu_tag[w_grantIdx*TAG_WIDTH +: TAG_WIDTH],
                          bus.i_fu_result[w_grantIdx*DATA_WIDTH +: DATA_WIDTH]};

    // Pointer, occupancy and round-robin bookkeeping; reset drops all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_grantValid) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                r_rrPtr <= (w_grantIdx == IDX_W'(NUM_FU - 1)) ? '0 : w_grantIdx + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_grantValid, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is left unreset; the head is masked by o_cdb_valid.
    always_ff @(posedge clk) begin
        if (w_grantValid) begin
            r_mem[r_wrPtr] <= w_pushEntry;
        end
    end

    assign bus.o_fu_queued  = w_grantMask;
    assign bus.o_cdb_valid  = (r_count != '0);
    assign {bus.o_cdb_tag, bus.o_cdb_data} = r_mem[r_rdPtr];
    assign bus.o_fifo_count = r_count;
    assign bus.o_fifo_full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: doc/cdb_broadcast_arbiter.md
Name: cdb_broadcast_arbiter

Overview:
- Shares the single common-data-bus (CDB) broadcast port among NUM_FU functional units.
- Each cycle, at most one FU with done asserted is granted by round-robin. Its result and execution tag are pushed into a small broadcast FIFO, and queued is returned to that FU in the same cycle so the FU can go idle.
- The FIFO head is presented on the CDB with a valid/ready handshake toward the reservation stations and reorder buffer.

Parameters:
- NUM_FU, 4, number of requesting functional units (at least 2).
- DATA_WIDTH, 32, result width.
- TAG_WIDTH, 7, execution tag width.
- DEPTH, 4, broadcast FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fu_done  in  NUM_FU  per-FU result-ready request. Held by the FU until its fu_queued is seen.
- fu_result  in  NUM_FU*DATA_WIDTH  FU i result at bits [i*DATA_WIDTH +: DATA_WIDTH].
- fu_tag  in  NUM_FU*TAG_WIDTH  FU i tag at bits [i*TAG_WIDTH +: TAG_WIDTH].
- fu_queued  out  NUM_FU  one-hot (or zero) grant. Combinational, same cycle as fu_done.
- cdb_valid  out  1  FIFO head valid.
- cdb_data  out  DATA_WIDTH  head result.
- cdb_tag  out  TAG_WIDTH  head tag.
- cdb_ready  in  1  consumer accepts head this cycle.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- fifo_full  out  1  fifo_count == DEPTH.

Behaviour:
- Reset, applied at posedge with rst=1:
  - rr_ptr=0, wr_ptr=0, rd_ptr=0, count=0.
  - Therefore cdb_valid=0, fifo_full=0, fifo_count=0.
  - FIFO storage is not reset; cdb_data and cdb_tag are don't-care while cdb_valid=0.
  - While rst=1, fu_queued=0.
  - Reset mid-operation discards all queued entries. An FU holding done is re-arbitrated from rr_ptr=0 after reset.
- Definitions:
  - pop = cdb_valid & cdb_ready.
  - can_push = (count < DEPTH) | pop. Pushing into a full FIFO is allowed only when a pop happens in the same cycle.
- Arbitration (combinational):
  - If can_push, grant the first i with fu_done[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - fu_queued[i]=1 only for the granted i.
  - No grant when can_push=0 or fu_done==0.
- Push at posedge when a grant exists:
  - mem[wr_ptr] <= {fu_tag[i], fu_result[i]}; wr_ptr <= wr_ptr+1 (wraps mod DEPTH).
  - rr_ptr <= (i+1) mod NUM_FU.
  - rr_ptr is unchanged when there is no grant.
- Pop at posedge when pop=1: rd_ptr <= rd_ptr+1 (wraps mod DEPTH).
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both or neither: unchanged.
- Outputs:
  - cdb_valid = (count != 0).
  - {cdb_tag, cdb_data} = mem[rd_ptr], combinational read of the registered array.
- Latency and ordering:
  - A granted result is visible on the CDB the cycle after grant at the earliest (empty FIFO).
  - Entries leave in grant order; no reordering.
- Throughput: one push and one pop per cycle sustained.
- Head stability: while cdb_valid=1 and cdb_ready=0, cdb_data and cdb_tag are stable.
- Fairness: a requester holding fu_done is granted within NUM_FU grants.
- cdb_ready while cdb_valid=0 has no effect.

Test Plan:
- Reset, then one request: fu_done=4'b0100, fu_result[2]=32'hDEAD_BEEF, fu_tag[2]=7'h15, cdb_ready=1 -> fu_queued=4'b0100 that cycle. Next cycle cdb_valid=1, cdb_data=DEADBEEF, cdb_tag=15. The cycle after, cdb_valid=0 and count=0.
- Round-robin: all four fu_done held high, each dropped the cycle after its grant, cdb_ready=1 -> grants in order FU0, FU1, FU2, FU3, one per cycle. CDB tags emerge in the same order. A new FU0 request afterwards (rr_ptr=0) is granted immediately.
- Full and backpressure: cdb_ready=0 with continuous requests -> exactly 4 grants, then fifo_full=1, fu_queued=0 and the head is stable. Raising cdb_ready for one cycle gives one pop and one push in the same cycle, with count staying 4.
- Wrap-around: push and pop 10 entries with tags 0..9, using random cdb_ready with about 50% duty -> tags observed in order 0..9. Pointers wrap mod 4 with no loss or duplicate. count never exceeds 4.
- Reset mid-operation: 3 entries queued and FU1 requesting, then rst pulsed for 1 cycle -> cdb_valid=0, count=0 and fu_queued=0 during rst. After rst, FU1 is granted first, its entry is the only one on the CDB, and no stale entries are broadcast.
